// File: rtl/fetch_mem_ctrl.sv
// fetch_mem_ctrl: credit-limited instruction fetch from a fixed-latency SRAM,
// with a LAT-stage tag pipeline feeding an in-order response FIFO.
module fetch_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 14,
    parameter int LAT     = 1,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [ADDR_W-1:0]  rsp_addr,
    output logic               rsp_err,
    input  logic               flush,
    output logic               sram_ceb,
    output logic [SRAM_AW-1:0] sram_a,
    input  logic [DATA_W-1:0]  sram_do,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 1 + ADDR_W + DATA_W;

    logic              accept, pop, busy_q;
    logic [CW-1:0]     cnt, cnt_n;
    logic [PW-1:0]     wp, rp;
    logic [LAT:1]      pv, pe;
    logic [ADDR_W-1:0] pa [1:LAT];
    logic [EW-1:0]     mem [DEPTH];

    // credits come only from the registered count, so rsp_ready never reaches req_ready
    assign req_ready = !rst && !flush && (cnt < CW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign sram_ceb  = !accept;
    assign sram_a    = req_addr[SRAM_AW+1:2];
    assign rsp_valid = !rst && (wp != rp);
    assign pop       = rsp_valid && rsp_ready;
    assign {rsp_err, rsp_addr, rsp_data} = mem[rp[AW-1:0]];
    assign busy      = busy_q && !rst;
    assign cnt_n     = flush ? '0 : cnt + CW'(accept) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            pv     <= '0;
        end else begin
            cnt    <= cnt_n;
            busy_q <= cnt_n != '0;
            wp     <= flush ? '0 : wp + PW'(pv[LAT]);
            rp     <= flush ? '0 : rp + PW'(pop);
            pv[1]  <= accept;
            for (int i = 2; i <= LAT; i++) pv[i] <= flush ? 1'b0 : pv[i-1];
        end
    end

    // tag pipeline lines up addr/err with sram_do; no reset needed on data
    always_ff @(posedge clk) begin
        pa[1] <= req_addr;
        pe[1] <= req_addr[1:0] != 2'b00;
        for (int i = 2; i <= LAT; i++) begin
            pa[i] <= pa[i-1];
            pe[i] <= pe[i-1];
        end
        if (pv[LAT] && !flush) mem[wp[AW-1:0]] <= {pe[LAT], pa[LAT], sram_do};
    end
endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// tb_fetch_mem_ctrl: directed checks of fetch_mem_ctrl at LAT=1/DEPTH=4
// and LAT=3/DEPTH=8 against behavioural SRAM models.
module tb_fetch_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, req_valid, rsp_ready, flush;
    logic [31:0] req_addr;
    logic        req_ready, rsp_valid, rsp_err, sram_ceb, busy;
    logic [31:0] rsp_data, rsp_addr, sram_do;
    logic [13:0] sram_a;

    logic        rv3, rr3, fl3;
    logic [31:0] ra3;
    logic        ready3, valid3, err3, ceb3, busy3;
    logic [31:0] data3, addr3, do3, s1, s2;
    logic [13:0] a3;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    fetch_mem_ctrl u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .flush(flush), .sram_ceb(sram_ceb), .sram_a(sram_a),
        .sram_do(sram_do), .busy(busy)
    );

    fetch_mem_ctrl #(.LAT(3), .DEPTH(8)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(ready3),
        .req_addr(ra3), .rsp_valid(valid3), .rsp_ready(rr3),
        .rsp_data(data3), .rsp_addr(addr3), .rsp_err(err3),
        .flush(fl3), .sram_ceb(ceb3), .sram_a(a3),
        .sram_do(do3), .busy(busy3)
    );

    function automatic logic [31:0] word(input logic [13:0] a);
        return (a == 14'd4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(a));
    endfunction

    always @(posedge clk) if (!sram_ceb) sram_do <= word(sram_a);

    always @(posedge clk) begin
        s1  <= word(a3);
        s2  <= s1;
        do3 <= s2;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; req_valid = 0; req_addr = 0; rsp_ready = 0; flush = 0;
        rv3 = 0; ra3 = 0; rr3 = 1; fl3 = 0;
        tick; tick;
        req_valid = 1; #1;
        check("rst_ready", req_ready, 0);
        check("rst_ceb", sram_ceb, 1);
        check("rst_rspv", rsp_valid, 0);
        check("rst_busy", busy, 0);
        req_valid = 0;
        tick; rst = 0; #1;
        check("post_rst_ready", req_ready, 1);

        // single aligned fetch, LAT=1
        req_valid = 1; req_addr = 32'h10; #1;
        check("single_sram_a", sram_a, 4);
        check("single_ceb", sram_ceb, 0);
        tick; req_valid = 0; #1;
        check("single_early", rsp_valid, 0);
        check("single_busy", busy, 1);
        tick; #1;
        check("single_valid", rsp_valid, 1);
        check("single_data", rsp_data, 32'hDEAD_BEEF);
        check("single_addr", rsp_addr, 32'h10);
        check("single_err", rsp_err, 0);
        rsp_ready = 1;
        tick; rsp_ready = 0; #1;
        check("single_drained", rsp_valid, 0);
        check("single_idle", busy, 0);

        // misaligned fetch
        req_valid = 1; req_addr = 32'h6; #1;
        check("mis_sram_a", sram_a, 1);
        tick; req_valid = 0;
        tick; #1;
        check("mis_valid", rsp_valid, 1);
        check("mis_err", rsp_err, 1);
        check("mis_data", rsp_data, 32'hC0DE_0001);
        check("mis_addr", rsp_addr, 32'h6);
        rsp_ready = 1;
        tick; rsp_ready = 0;

        // fill to DEPTH with rsp_ready low, then drain
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_addr = 32'h20 + 32'(4 * i); #1;
            check("fill_ready", req_ready, 1);
            tick;
        end
        req_addr = 32'h30; #1;
        check("full_ready", req_ready, 0);
        check("full_ceb", sram_ceb, 1);
        tick; #1;
        check("full_ready2", req_ready, 0);
        check("hold_data0", rsp_data, 32'hC0DE_0008);
        tick; #1;
        check("hold_data1", rsp_data, 32'hC0DE_0008);
        check("hold_addr", rsp_addr, 32'h20);
        rsp_ready = 1; #1;
        check("pop_ready_same", req_ready, 0);
        tick; #1;
        check("credit_back", req_ready, 1);
        check("drain_1", rsp_data, 32'hC0DE_0009);
        tick; req_valid = 0; #1;
        check("drain_2", rsp_data, 32'hC0DE_000A);
        tick; #1;
        check("drain_3", rsp_data, 32'hC0DE_000B);
        tick; #1;
        check("drain_4", rsp_data, 32'hC0DE_000C);
        check("drain_4_addr", rsp_addr, 32'h30);
        tick; #1;
        check("drain_empty", rsp_valid, 0);
        check("drain_busy", busy, 0);
        rsp_ready = 0;

        // flush with three in flight
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; req_addr = 32'h40 + 32'(4 * i); #1;
            tick;
        end
        req_addr = 32'h4C; flush = 1; #1;
        check("flush_pre_valid", rsp_valid, 1);
        check("flush_pre_busy", busy, 1);
        check("flush_no_accept", req_ready, 0);
        check("flush_ceb", sram_ceb, 1);
        tick; flush = 0; req_valid = 0; #1;
        check("flush_valid", rsp_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick; #1;
            check("flush_stale", rsp_valid, 0);
        end
        req_valid = 1; req_addr = 32'h50; #1;
        tick; req_valid = 0;
        tick; #1;
        check("post_flush_valid", rsp_valid, 1);
        check("post_flush_data", rsp_data, 32'hC0DE_0014);
        check("post_flush_addr", rsp_addr, 32'h50);
        rsp_ready = 1;
        tick; rsp_ready = 0; #1;
        check("post_flush_empty", rsp_valid, 0);

        // reset with the FIFO full
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_addr = 32'h60 + 32'(4 * i); #1;
            tick;
        end
        req_valid = 0;
        tick; #1;
        check("prerst_valid", rsp_valid, 1);
        check("prerst_busy", busy, 1);
        check("prerst_ready", req_ready, 0);
        rst = 1; req_valid = 1;
        tick; #1;
        check("midrst_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ceb", sram_ceb, 1);
        check("midrst_ready", req_ready, 0);
        tick; rst = 0; req_valid = 0; #1;
        check("afterrst_ready", req_ready, 1);
        check("afterrst_valid", rsp_valid, 0);
        check("afterrst_busy", busy, 0);
        req_valid = 1; req_addr = 32'h8; #1;
        tick; req_valid = 0;
        tick; #1;
        check("afterrst_rsp", rsp_valid, 1);
        check("afterrst_data", rsp_data, 32'hC0DE_0002);
        check("afterrst_addr", rsp_addr, 32'h8);
        rsp_ready = 1;
        tick; rsp_ready = 0;

        // LAT=3 streaming: one accept per cycle, first response at accept+4
        for (int c = 0; c < 14; c++) begin
            rv3 = c < 10; ra3 = 32'(4 * c); #1;
            if (c < 10) check("lat3_ready", ready3, 1);
            check("lat3_valid", valid3, c >= 4);
            if (c >= 4) begin
                check("lat3_data", data3, word(14'(c - 4)));
                check("lat3_addr", addr3, 32'(4 * (c - 4)));
            end
            tick;
        end
        rv3 = 0; #1;
        check("lat3_idle", busy3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
